// File: rtl/harris_response_sequencer_if.sv
// Harris response sequencer bus interface.
//
// Groups the window-input handshake, the response-output handshake and the
// busy flag. The window producer and response consumer drive through the
// master modport; the sequencer uses the slave modport.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. The source holds valid and its
// payload stable until that edge. ready may depend on nothing but the sink's
// own state. valid never waits on ready.
//
// Signals:
//   in_valid / in_ready  window channel
//   ix_win / iy_win      9 packed signed gradient samples, element k at
//                        bits [k*p_num_bits_in +: p_num_bits_in], raster order
//   scale                trace right-shift amount, taken with the window
//   out_valid / out_ready response channel
//   out                  signed Harris response
//   busy                 sequencer is working on or holding a window
interface harris_response_sequencer_if #(
  parameter int p_num_bits_in = 13,
  parameter int p_out_bits    = 18
);
  logic                          in_valid;
  logic                          in_ready;
  logic [9*p_num_bits_in-1:0]    ix_win;
  logic [9*p_num_bits_in-1:0]    iy_win;
  logic [3:0]                    scale;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [p_out_bits-1:0]  out;
  logic                          busy;

  modport master (
    output in_valid, ix_win, iy_win, scale, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, ix_win, iy_win, scale, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/harris_response_sequencer.sv
// Harris corner-response sequencer.
//
// Computes out = (A*C - B*B) / ((A+C) >>> scale) for one 3x3 window of Ix/Iy
// gradients, where A = sum Ix^2, B = sum Ix*Iy, C = sum Iy^2. One window is
// in flight at a time. Work is spread over many cycles so that a single
// small multiplier, a single wide multiplier and a bit-serial divider do
// all of the arithmetic.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   bus        slave side of harris_response_sequencer_if (window in,
//              response out, busy)
//   dbg_state  current FSM state encoding, for observation only
//
// Timing from the accepting edge: 27 MAC + DET1 + DET2 + CHK = 30 edges to
// the result when the trace is zero; otherwise CHK hands over to 56 divide
// steps plus FIN, 87 edges in total.
module harris_response_sequencer #(
  parameter int p_num_bits_in = 13,
  parameter int p_out_bits    = 18
) (
  input  logic                          clk,
  input  logic                          reset,
  harris_response_sequencer_if.slave    bus,
  output logic [2:0]                    dbg_state
);

  localparam int P  = p_num_bits_in;
  localparam int O  = p_out_bits;
  localparam int PW = 2 * P;        // one gradient product
  localparam int AW = 2 * P + 2;    // A/B/C accumulators
  localparam int DW = 2 * AW;       // determinant, dividend, quotient
  localparam int TW = AW + 1;       // trace (A+C)
  localparam int CW = $clog2(DW);   // divide step counter

  localparam logic signed [O-1:0] out_pos_max = {1'b0, {(O-1){1'b1}}};
  localparam logic signed [O-1:0] out_neg_min = {1'b1, {(O-1){1'b0}}};
  localparam logic [DW-1:0] q_pos_max = {{(DW-O+1){1'b0}}, {(O-1){1'b1}}};
  localparam logic [DW-1:0] q_neg_max = {{(DW-O){1'b0}}, 1'b1, {(O-1){1'b0}}};

  typedef enum logic [2:0] {
    s_idle = 3'd0,
    s_mac  = 3'd1,
    s_det1 = 3'd2,
    s_det2 = 3'd3,
    s_chk  = 3'd4,
    s_div  = 3'd5,
    s_fin  = 3'd6,
    s_done = 3'd7
  } state_t;

  state_t                 state;
  logic [9*P-1:0]         ix_r;
  logic [9*P-1:0]         iy_r;
  logic [3:0]             scale_r;
  logic [3:0]             pix;
  logic [1:0]             sub;
  logic signed [AW-1:0]   acc_a;
  logic signed [AW-1:0]   acc_b;
  logic signed [AW-1:0]   acc_c;
  logic signed [DW-1:0]   det;
  logic [TW-1:0]          div_d;
  logic [TW-1:0]          rem;
  logic [DW-1:0]          dvd;
  logic                   neg;
  logic [CW-1:0]          cnt;
  logic signed [O-1:0]    out_r;
  logic                   out_valid_r;
  logic                   in_ready_r;
  logic                   busy_r;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;
  assign bus.busy      = busy_r;
  assign dbg_state     = state;

  // Shared 13x13 multiplier. The window registers shift down one sample per
  // pixel, so the current pixel is always in the low P bits.
  // sub 0: Ix*Ix, sub 1: Ix*Iy, sub 2: Iy*Iy.
  logic signed [P-1:0]  ix_s, iy_s, mac_a, mac_b;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_x;

  assign ix_s   = ix_r[P-1:0];
  assign iy_s   = iy_r[P-1:0];
  assign mac_a  = (sub == 2'd2) ? iy_s : ix_s;
  assign mac_b  = (sub == 2'd0) ? ix_s : iy_s;
  assign prod   = mac_a * mac_b;
  assign prod_x = {{(AW-PW){prod[PW-1]}}, prod};

  // Shared wide multiplier: A*C in DET1, B*B in DET2.
  logic signed [AW-1:0] big_a, big_b;
  logic signed [DW-1:0] big_p;

  assign big_a = (state == s_det1) ? acc_a : acc_b;
  assign big_b = (state == s_det1) ? acc_c : acc_b;
  assign big_p = big_a * big_b;

  // Trace and operand magnitudes for the unsigned divider.
  logic signed [TW-1:0] trace_sum, trace_sh;
  logic [TW-1:0]        trace_mag;
  logic [DW-1:0]        det_mag;

  assign trace_sum = {acc_a[AW-1], acc_a} + {acc_c[AW-1], acc_c};
  assign trace_sh  = trace_sum >>> scale_r;
  assign trace_mag = trace_sh[TW-1] ? TW'(-trace_sh) : TW'(trace_sh);
  assign det_mag   = det[DW-1] ? DW'(-det) : DW'(det);

  // Restoring divide step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. The quotient bit shifts
  // into the vacated low end of dvd, so dvd ends up holding the quotient.
  logic [TW:0] rem_sh;
  logic        take;

  assign rem_sh = {rem, dvd[DW-1]};
  assign take   = (rem_sh >= {1'b0, div_d});

  // Sign restore and saturation of the unsigned quotient.
  logic signed [O-1:0] sat;

  always_comb begin
    sat = '0;
    if (!neg) begin
      sat = (dvd > q_pos_max) ? out_pos_max : O'(dvd);
    end else begin
      sat = (dvd > q_neg_max) ? out_neg_min : O'(-dvd);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= s_idle;
      ix_r        <= '0;
      iy_r        <= '0;
      scale_r     <= '0;
      pix         <= '0;
      sub         <= '0;
      acc_a       <= '0;
      acc_b       <= '0;
      acc_c       <= '0;
      det         <= '0;
      div_d       <= '0;
      rem         <= '0;
      dvd         <= '0;
      neg         <= 1'b0;
      cnt         <= '0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        s_idle: begin
          if (bus.in_valid && in_ready_r) begin
            ix_r       <= bus.ix_win;
            iy_r       <= bus.iy_win;
            scale_r    <= bus.scale;
            acc_a      <= '0;
            acc_b      <= '0;
            acc_c      <= '0;
            pix        <= '0;
            sub        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= s_mac;
          end else begin
            in_ready_r <= 1'b1;
          end
        end

        s_mac: begin
          case (sub)
            2'd0:    acc_a <= acc_a + prod_x;
            2'd1:    acc_b <= acc_b + prod_x;
            default: acc_c <= acc_c + prod_x;
          endcase
          if (sub == 2'd2) begin
            sub  <= '0;
            pix  <= pix + 4'd1;
            ix_r <= {{P{1'b0}}, ix_r[9*P-1:P]};
            iy_r <= {{P{1'b0}}, iy_r[9*P-1:P]};
            if (pix == 4'd8) begin
              state <= s_det1;
            end
          end else begin
            sub <= sub + 2'd1;
          end
        end

        s_det1: begin
          det   <= big_p;
          state <= s_det2;
        end

        s_det2: begin
          det   <= det - big_p;
          state <= s_chk;
        end

        s_chk: begin
          if (trace_sh == '0) begin
            out_r       <= '0;
            out_valid_r <= 1'b1;
            state       <= s_done;
          end else begin
            div_d <= trace_mag;
            rem   <= '0;
            dvd   <= det_mag;
            // A negative trace only arises from accumulator wrap; folding
            // its sign in keeps the quotient consistent with a true divide.
            neg   <= det[DW-1] ^ trace_sh[TW-1];
            cnt   <= '0;
            state <= s_div;
          end
        end

        s_div: begin
          rem <= take ? TW'(rem_sh - {1'b0, div_d}) : TW'(rem_sh);
          dvd <= {dvd[DW-2:0], take};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DW - 1)) begin
            state <= s_fin;
          end
        end

        s_fin: begin
          out_r       <= sat;
          out_valid_r <= 1'b1;
          state       <= s_done;
        end

        s_done: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state       <= s_idle;
          end
        end

        default: begin
          state <= s_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_harris_response_sequencer.sv
module tb_harris_response_sequencer;

  localparam int P = 13;
  localparam int O = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  harris_response_sequencer_if #(.p_num_bits_in(P), .p_out_bits(O)) bus ();
  logic [2:0] dbg_state;

  harris_response_sequencer #(.p_num_bits_in(P), .p_out_bits(O)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [O-1:0] exp_q[$];
  int           lat_q[$];
  int           acc_cyc = 0;
  logic         prev_ov = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the current window.
  int cur_ix[9];
  int cur_iy[9];

  function automatic void model(input int sc, output logic [O-1:0] res, output int lat);
    longint a, b, c, d, tr, q;
    a = 0; b = 0; c = 0;
    for (int k = 0; k < 9; k++) begin
      a += longint'(cur_ix[k]) * cur_ix[k];
      b += longint'(cur_ix[k]) * cur_iy[k];
      c += longint'(cur_iy[k]) * cur_iy[k];
    end
    d  = a * c - b * b;
    tr = (a + c) >>> sc;
    if (tr == 0) begin
      q   = 0;
      lat = 30;
    end else begin
      q   = d / tr;
      lat = 87;
    end
    if (q > 131071)  q = 131071;
    if (q < -131072) q = -131072;
    res = O'(q);
  endfunction

  // Output monitor: latency checked when out_valid rises, value checked at
  // the output handshake.
  always @(negedge clk) begin
    if (reset) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) acc_cyc = cyc + 1;
      if (bus.out_valid && !prev_ov) begin
        if (lat_q.size() == 0) begin
          check("spurious_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          int l;
          l = lat_q.pop_front();
          check("latency", 64'(cyc - acc_cyc), 64'(l));
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(bus.out_valid), 64'd0);
        end else begin
          logic [O-1:0] e;
          e = exp_q.pop_front();
          check("out", 64'(bus.out), 64'(e));
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_win();
    for (int k = 0; k < 9; k++) begin
      cur_ix[k] = 0;
      cur_iy[k] = 0;
    end
  endtask

  task automatic put_win(input int sc);
    for (int k = 0; k < 9; k++) begin
      bus.ix_win[k*P +: P] = P'(cur_ix[k]);
      bus.iy_win[k*P +: P] = P'(cur_iy[k]);
    end
    bus.scale = 4'(sc);
  endtask

  task automatic push_exp(input int sc);
    logic [O-1:0] r;
    int l;
    model(sc, r, l);
    exp_q.push_back(r);
    lat_q.push_back(l);
  endtask

  // Present the window, wait for acceptance, then scramble the inputs.
  task automatic send(input int sc, input bit push);
    bit ok;
    if (push) push_exp(sc);
    @(posedge clk); #1;
    put_win(sc);
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 64'd0, 64'd1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.ix_win   = {4{$urandom}};
    bus.iy_win   = {4{$urandom}};
    bus.scale    = 4'($urandom_range(15));
    @(negedge clk);
    if (ok) begin
      check("busy_after_accept", 64'(bus.busy), 64'd1);
      check("in_ready_after_accept", 64'(bus.in_ready), 64'd0);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      lat_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run_case(input int sc);
    send(sc, 1'b1);
    wait_drain();
  endtask

  task automatic set_case1();
    clear_win();
    cur_ix[0] = 3;
    cur_iy[4] = 4;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    bus.in_valid  = 1'b0;
    bus.ix_win    = '0;
    bus.iy_win    = '0;
    bus.scale     = '0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out", 64'(bus.out), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed windows
    set_case1();
    run_case(0);                 // 5, 87 clocks
    run_case(2);                 // 24
    run_case(15);                // trace 0 -> 0, 30 clocks
    clear_win();
    run_case(0);                 // all zero -> 0, 30 clocks
    clear_win();
    cur_ix[0] = 3060;
    cur_iy[4] = 3060;
    run_case(0);                 // saturates to 131071
    clear_win();
    cur_ix[8] = -7;
    cur_iy[8] = 5;
    cur_ix[2] = 11;
    run_case(1);

    // Random windows
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 9; k++) begin
        cur_ix[k] = int'($urandom_range(4000)) - 2000;
        cur_iy[k] = int'($urandom_range(4000)) - 2000;
      end
      run_case(int'($urandom_range(6)));
    end

    // Backpressure with a second window waiting
    set_case1();
    bus.out_ready = 1'b0;
    send(2, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("bp_valid_seen", 64'(seen), 64'd1);
    clear_win();
    cur_ix[0] = 3060;
    cur_iy[4] = 3060;
    push_exp(0);
    @(posedge clk); #1;
    put_win(0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_stable", 64'(bus.out), 64'd24);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;          // output handshake happens here
    @(negedge clk);
    check("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
    check("bp_valid_dropped", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;          // second window accepted here
    bus.in_valid = 1'b0;
    bus.ix_win   = {4{$urandom}};
    wait_drain();

    // Reset in the middle of the divide
    set_case1();
    send(0, 1'b0);
    repeat (39) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out", 64'(bus.out), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (100) @(negedge clk);
    check("midrst_no_output", 64'(bus.out_valid), 64'd0);
    set_case1();
    run_case(0);                 // 5 with nominal latency

    repeat (5) @(posedge clk);
    check("queue_empty", 64'(exp_q.size() + lat_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
